// File: rtl/color_pkg.sv
// Colour codes, sensor filter codes and the classifier FSM states, shared by the
// colour sensor front-end and the downstream change detector.
package color_pkg;

    localparam logic [2:0] COLOR_NONE  = 3'd0;
    localparam logic [2:0] COLOR_RED   = 3'd1;
    localparam logic [2:0] COLOR_GREEN = 3'd2;
    localparam logic [2:0] COLOR_BLUE  = 3'd3;

    // {S2,S3} photodiode filter selects; CLEAR is listed for completeness only
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL_R  = 3'd1,
        ST_CNT_R  = 3'd2,
        ST_SEL_G  = 3'd3,
        ST_CNT_G  = 3'd4,
        ST_SEL_B  = 3'd5,
        ST_CNT_B  = 3'd6,
        ST_DECIDE = 3'd7
    } state_t;

    function automatic logic [1:0] filter_for_state(input state_t st);
        logic [1:0] code;
        code = FILT_RED;
        case (st)
            ST_SEL_G, ST_CNT_G: code = FILT_GREEN;
            ST_SEL_B, ST_CNT_B: code = FILT_BLUE;
            default:            code = FILT_RED;
        endcase
        return code;
    endfunction

    function automatic logic is_select_state(input state_t st);
        return (st == ST_SEL_R) || (st == ST_SEL_G) || (st == ST_SEL_B);
    endfunction

    function automatic logic is_count_state(input state_t st);
        return (st == ST_CNT_R) || (st == ST_CNT_G) || (st == ST_CNT_B);
    endfunction

endpackage

// File: rtl/edge_pulse_counter.sv
// Synchronises the sensor square wave, detects rising edges and counts them in a
// saturating counter; one instance is time-shared across the three filter phases.
module edge_pulse_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             pulse;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pulse = sync2 & ~sync3;

    // count_next is exported so the final pulse of a gate window is not lost when latching
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (count_en && pulse && (count != CNT_MAX)) begin
            count_next = count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/color_sensor_classifier.sv
// TCS3200 front-end: steps the filter through red, green and blue, counts sensor
// edges in a fixed gate per filter and reports the dominant colour with a strobe.
module color_sensor_classifier
    import color_pkg::*;
#(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sensor_out,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic [2:0]       color,
    output logic             data_set_done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt
);

    localparam int TIMER_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] GATE_LOAD   = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [31:0]        MIN_WIN     = 32'(MIN_COUNT);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               timer_done;
    logic               cnt_clear;
    logic               cnt_enable;
    logic [CNT_W-1:0]   cnt_value;
    logic [2:0]         win_color;
    logic [CNT_W-1:0]   win_count;
    logic [2:0]         decided_color;

    // 20% output frequency scaling is fixed
    assign s0 = 1'b1;
    assign s1 = 1'b0;

    assign timer_done = (timer == '0);

    edge_pulse_counter #(
        .CNT_W(CNT_W)
    ) u_edge_counter (
        .clk       (clk),
        .reset     (reset),
        .sensor_in (sensor_out),
        .clear     (cnt_clear),
        .count_en  (cnt_enable),
        .count_next(cnt_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // enable is only looked at in IDLE and DECIDE, so a started frame always runs to the end
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        {s2, s3}   = filter_for_state(state);

        unique case (state)
            ST_IDLE:   if (enable) state_next = ST_SEL_R;
            ST_SEL_R:  if (timer_done) state_next = ST_CNT_R;
            ST_CNT_R:  if (timer_done) state_next = ST_SEL_G;
            ST_SEL_G:  if (timer_done) state_next = ST_CNT_G;
            ST_CNT_G:  if (timer_done) state_next = ST_SEL_B;
            ST_SEL_B:  if (timer_done) state_next = ST_CNT_B;
            ST_CNT_B:  if (timer_done) state_next = ST_DECIDE;
            ST_DECIDE: state_next = enable ? ST_SEL_R : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase

        // Holding the counter clear through the settle window drops filter-change artefacts
        cnt_clear  = is_select_state(state);
        cnt_enable = is_count_state(state);
    end

    always_comb begin
        timer_next = timer_done ? timer : (timer - TIMER_ONE);
        if (state_next != state) begin
            if (is_select_state(state_next)) begin
                timer_next = SETTLE_LOAD;
            end else if (is_count_state(state_next)) begin
                timer_next = GATE_LOAD;
            end else begin
                timer_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
        end else if (timer_done) begin
            if (state == ST_CNT_R) red_cnt   <= cnt_value;
            if (state == ST_CNT_G) green_cnt <= cnt_value;
            if (state == ST_CNT_B) blue_cnt  <= cnt_value;
        end
    end

    // A tie for the top count leaves no winner, which also reports as no colour
    always_comb begin
        win_color = COLOR_NONE;
        win_count = '0;
        if ((red_cnt > green_cnt) && (red_cnt > blue_cnt)) begin
            win_color = COLOR_RED;
            win_count = red_cnt;
        end else if ((green_cnt > red_cnt) && (green_cnt > blue_cnt)) begin
            win_color = COLOR_GREEN;
            win_count = green_cnt;
        end else if ((blue_cnt > red_cnt) && (blue_cnt > green_cnt)) begin
            win_color = COLOR_BLUE;
            win_count = blue_cnt;
        end
        decided_color = (32'(win_count) >= MIN_WIN) ? win_color : COLOR_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color         <= COLOR_NONE;
            data_set_done <= 1'b0;
        end else begin
            data_set_done <= (state == ST_DECIDE);
            if (state == ST_DECIDE) color <= decided_color;
        end
    end

endmodule

// File: tb/tb_color_sensor_classifier.sv
// Directed bench for color_sensor_classifier: table of whole-frame vectors plus
// hand-written sequences for back-to-back frames, reset, enable timing and saturation.
module tb_color_sensor_classifier;

    localparam int GATE      = 100;
    localparam int SETTLE    = 10;
    localparam int PHASE     = SETTLE + GATE;
    localparam int FRAME_LEN = 331;

    localparam int PAT_PERIODIC = 0;
    localparam int PAT_SEL_ONLY = 1;
    localparam int PAT_SAT      = 2;

    typedef struct {
        int rp;
        int gp;
        int bp;
        int pat;
        int exp_r;
        int exp_g;
        int exp_b;
        int exp_color;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       sensor_out;
    logic       s0, s1, s2, s3;
    logic [2:0] color;
    logic       data_set_done;
    logic [7:0] red_cnt, green_cnt, blue_cnt;

    logic       s0_w4, s1_w4, s2_w4, s3_w4;
    logic [2:0] color_w4;
    logic       data_set_done_w4;
    logic [3:0] red_cnt_w4, green_cnt_w4, blue_cnt_w4;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fs = 0;
    int   frame_t = -1;
    bit   frame_active = 1'b0;
    int   strobes = 0;
    int   last_strobe = 0;
    int   pat = PAT_PERIODIC;
    int   rp = 0, gp = 0, bp = 0;
    vec_t vecs [9];

    color_sensor_classifier #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(8), .MIN_COUNT(5)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sensor_out(sensor_out),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .color(color),
        .data_set_done(data_set_done), .red_cnt(red_cnt),
        .green_cnt(green_cnt), .blue_cnt(blue_cnt)
    );

    color_sensor_classifier #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(4), .MIN_COUNT(5)
    ) dut_w4 (
        .clk(clk), .reset(reset), .enable(enable), .sensor_out(sensor_out),
        .s0(s0_w4), .s1(s1_w4), .s2(s2_w4), .s3(s3_w4), .color(color_w4),
        .data_set_done(data_set_done_w4), .red_cnt(red_cnt_w4),
        .green_cnt(green_cnt_w4), .blue_cnt(blue_cnt_w4)
    );

    always #5 clk = ~clk;

    // Sensor level for frame cycle t (t = 0 is the first SEL_R cycle)
    function automatic logic sensor_level(input int t, input int tick);
        int p;
        int ofs;
        if (t < 0) return 1'b0;
        if (pat == PAT_PERIODIC) begin
            p = (t < PHASE) ? rp : ((t < 2 * PHASE) ? gp : bp);
            if (p == 0) return 1'b0;
            return (tick % p) < (p / 2);
        end else if (pat == PAT_SEL_ONLY) begin
            ofs = t % PHASE;
            return (t < 3 * PHASE) && (ofs <= 4) && (ofs % 2 == 0);
        end else begin
            if (t >= 10 && t < 100) return (t % 2 == 0);
            return (t == 150) || (t == 170) || (t == 190) ||
                   (t == 260) || (t == 280) || (t == 300);
        end
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (data_set_done) begin
            strobes++;
            last_strobe = cyc;
        end
        frame_t    = frame_active ? ((cyc - fs - 1) % FRAME_LEN) : -1;
        sensor_out = sensor_level(frame_t, cyc);
    endtask

    task automatic checkOutput(input string what, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
        end
    endtask

    task automatic checkFrame(input string tag, input vec_t v);
        checkOutput({tag, " color"}, int'(color), v.exp_color);
        checkOutput({tag, " red_cnt"}, int'(red_cnt), v.exp_r);
        checkOutput({tag, " green_cnt"}, int'(green_cnt), v.exp_g);
        checkOutput({tag, " blue_cnt"}, int'(blue_cnt), v.exp_b);
    endtask

    // Runs one frame from IDLE; enable drops once the frame reaches cycle drop_at
    task automatic applyStimulus(input string tag, input vec_t v, input int drop_at);
        int start;
        bit got;
        pat = v.pat;
        rp  = v.rp;
        gp  = v.gp;
        bp  = v.bp;
        start        = strobes;
        fs           = cyc;
        frame_active = 1'b1;
        enable       = 1'b1;
        got          = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            if (frame_t == drop_at) enable = 1'b0;
            if (strobes != start) got = 1'b1;
        end
        enable = 1'b0;
        checkOutput({tag, " strobe seen"}, int'(got), 1);
        checkOutput({tag, " strobe latency"}, last_strobe - fs - 1, 331);
        step();
        step();
        checkOutput({tag, " strobe count"}, strobes - start, 1);
    endtask

    initial begin
        int   start;
        int   prev;
        int   stamps [3];
        bit   reached;
        vec_t sat_vec;

        reset      = 1'b1;
        enable     = 1'b0;
        sensor_out = 1'b0;

        vecs[0] = '{4, 10, 20, PAT_PERIODIC, 25, 10, 5, 1};
        vecs[1] = '{20, 20, 4, PAT_PERIODIC, 5, 5, 25, 3};
        vecs[2] = '{10, 4, 20, PAT_PERIODIC, 10, 25, 5, 2};
        vecs[3] = '{10, 10, 10, PAT_PERIODIC, 10, 10, 10, 0};
        vecs[4] = '{0, 0, 0, PAT_PERIODIC, 0, 0, 0, 0};
        vecs[5] = '{10, 10, 20, PAT_PERIODIC, 10, 10, 5, 0};
        vecs[6] = '{25, 50, 0, PAT_PERIODIC, 4, 2, 0, 0};
        vecs[7] = '{20, 50, 0, PAT_PERIODIC, 5, 2, 0, 1};
        vecs[8] = '{0, 0, 0, PAT_SEL_ONLY, 0, 0, 0, 0};

        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        step();
        checkOutput("reset color", int'(color), 0);
        checkOutput("reset strobe", int'(data_set_done), 0);
        checkOutput("reset filter", int'({s2, s3}), 0);
        checkOutput("reset s0", int'(s0), 1);
        checkOutput("reset s1", int'(s1), 0);
        checkOutput("reset red_cnt", int'(red_cnt), 0);
        checkOutput("reset green_cnt", int'(green_cnt), 0);
        checkOutput("reset blue_cnt", int'(blue_cnt), 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i], 0);
            checkFrame($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] back-to-back blue frames");
        pat = PAT_PERIODIC; rp = 20; gp = 20; bp = 4;
        start = strobes;
        prev  = strobes;
        stamps = '{0, 0, 0};
        fs = cyc;
        frame_active = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 1200 && (strobes - start) < 3; i++) begin
            step();
            if (strobes != prev) begin
                if (strobes - start - 1 < 3) stamps[strobes - start - 1] = last_strobe;
                prev = strobes;
            end
            if ((strobes - start) == 2 && frame_t >= 300) enable = 1'b0;
            if (frame_t == 5)   checkOutput("b2b filter red", int'({s2, s3}), 0);
            if (frame_t == 115) checkOutput("b2b filter green", int'({s2, s3}), 3);
            if (frame_t == 225) checkOutput("b2b filter blue", int'({s2, s3}), 1);
        end
        enable = 1'b0;
        checkOutput("b2b strobes", strobes - start, 3);
        checkOutput("b2b first latency", stamps[0] - fs - 1, 331);
        checkOutput("b2b spacing 1", stamps[1] - stamps[0], 331);
        checkOutput("b2b spacing 2", stamps[2] - stamps[1], 331);
        checkOutput("b2b color", int'(color), 3);
        checkOutput("b2b blue_cnt", int'(blue_cnt), 25);
        step();
        step();

        $display("[TB] reset during green count");
        pat = PAT_PERIODIC; rp = 4; gp = 10; bp = 20;
        fs = cyc;
        frame_active = 1'b1;
        enable = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            step();
            if (frame_t == 0) enable = 1'b0;
            if (frame_t == 150) reached = 1'b1;
        end
        checkOutput("reached CNT_G", int'(reached), 1);
        reset = 1'b1;
        start = strobes;
        step();
        checkOutput("midreset color", int'(color), 0);
        checkOutput("midreset filter", int'({s2, s3}), 0);
        checkOutput("midreset strobe", int'(data_set_done), 0);
        checkOutput("midreset red_cnt", int'(red_cnt), 0);
        reset = 1'b0;
        frame_active = 1'b0;
        for (int i = 0; i < 400; i++) step();
        checkOutput("midreset no strobe", strobes - start, 0);
        applyStimulus("after reset", vecs[0], 0);
        checkFrame("after reset", vecs[0]);

        $display("[TB] enable dropped mid-frame");
        applyStimulus("enable drop", vecs[1], 50);
        checkFrame("enable drop", vecs[1]);
        start = strobes;
        frame_active = 1'b0;
        for (int i = 0; i < 400; i++) step();
        checkOutput("enable drop idle strobes", strobes - start, 0);
        checkOutput("enable drop idle filter", int'({s2, s3}), 0);

        $display("[TB] counter saturation");
        sat_vec = '{0, 0, 0, PAT_SAT, 45, 3, 3, 1};
        applyStimulus("saturation", sat_vec, 0);
        checkFrame("saturation w8", sat_vec);
        checkOutput("saturation w4 red_cnt", int'(red_cnt_w4), 15);
        checkOutput("saturation w4 green_cnt", int'(green_cnt_w4), 3);
        checkOutput("saturation w4 blue_cnt", int'(blue_cnt_w4), 3);
        checkOutput("saturation w4 color", int'(color_w4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
